// File: rtl/dm_arbiter.sv
// Purpose: shares one single-ported data memory between port 0 (CPU) and port 1 (DMA/debug); partial writes become read-modify-write.
// Latency: grant edge to Ack is 2 cycles (read, full write, BE=0) or 3 cycles (partial write); 1-cycle IDLE bubble between accesses.
// Backpressure: requesters hold Req until their Ack; a losing request waits in place and is never dropped.
module dm_arbiter #(
    parameter bit RR_EN  = 1'b1,
    parameter int DATA_W = 32
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Req0,
    input  logic                Req1,
    input  logic                We0,
    input  logic                We1,
    input  logic [31:0]         Addr0,
    input  logic [31:0]         Addr1,
    input  logic [DATA_W-1:0]   WData0,
    input  logic [DATA_W-1:0]   WData1,
    input  logic [DATA_W/8-1:0] BE0,
    input  logic [DATA_W/8-1:0] BE1,
    output logic                Ack0,
    output logic                Ack1,
    output logic [DATA_W-1:0]   RData0,
    output logic [DATA_W-1:0]   RData1,
    output logic                Busy,
    output logic [31:0]         DM_Addr,
    output logic [DATA_W-1:0]   DM_WriteData,
    output logic                DM_MemRead,
    output logic                DM_MemWrite,
    input  logic [DATA_W-1:0]   DM_ReadData
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, DONE} state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [31:0]         addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                port_q, port_d;
    logic                last_grant_q, last_grant_d;
    logic [DATA_W-1:0]   old_q, old_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                grant;
    logic [DATA_W-1:0]   merged;

    // State and datapath registers; reset drops any access in flight.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            port_q       <= 1'b0;
            last_grant_q <= 1'b1;
            old_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            port_q       <= port_d;
            last_grant_q <= last_grant_d;
            old_q        <= old_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Byte-lane merge of the latched write data over the word read in ACCESS.
    always_comb begin
        merged = '0;
        for (int i = 0; i < BE_W; i++) begin
            merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : old_q[8*i +: 8];
        end
    end

    // Next-state and latch logic: arbitrate in IDLE, then sequence the latched access.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        port_d       = port_q;
        last_grant_d = last_grant_q;
        old_d        = old_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        // On a tie, round-robin favours the port not served last; otherwise whoever asks.
        grant        = (Req0 && Req1) ? (RR_EN ? ~last_grant_q : 1'b0) : Req1;
        case (state_q)
            IDLE: begin
                if (Req0 || Req1) begin
                    port_d  = grant;
                    we_d    = grant ? We1 : We0;
                    addr_d  = grant ? Addr1 : Addr0;
                    wdata_d = grant ? WData1 : WData0;
                    be_d    = grant ? BE1 : BE0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    if (port_q) rdata1_d = DM_ReadData;
                    else        rdata0_d = DM_ReadData;
                    state_d = DONE;
                end else if (be_q == '1 || be_q == '0) begin
                    state_d = DONE;
                end else begin
                    old_d   = DM_ReadData;
                    state_d = MERGE;
                end
            end
            MERGE: state_d = DONE;
            DONE: begin
                last_grant_d = port_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state only, so reset clears them immediately.
    always_comb begin
        Ack0         = 1'b0;
        Ack1         = 1'b0;
        DM_Addr      = '0;
        DM_WriteData = '0;
        DM_MemRead   = 1'b0;
        DM_MemWrite  = 1'b0;
        case (state_q)
            ACCESS: begin
                DM_Addr    = addr_q & ~32'h3;
                DM_MemRead = 1'b1;
                if (we_q && be_q == '1) begin
                    DM_MemWrite  = 1'b1;
                    DM_WriteData = wdata_q;
                end
            end
            MERGE: begin
                DM_Addr      = addr_q & ~32'h3;
                DM_WriteData = merged;
                DM_MemWrite  = 1'b1;
            end
            DONE: begin
                Ack0 = ~port_q;
                Ack1 = port_q;
            end
            default: ;
        endcase
    end

    assign Busy   = (state_q != IDLE);
    assign RData0 = rdata0_q;
    assign RData1 = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: a round-robin instance with a modelled memory, plus a fixed-priority instance.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
// Every step has a fixed cycle count, so the run always terminates.
module tb_dm_arbiter;

    logic        Clk;
    logic        Rst;
    logic        Req0, Req1, We0, We1;
    logic [31:0] Addr0, Addr1, WData0, WData1;
    logic [3:0]  BE0, BE1;
    logic        Ack0, Ack1, Busy, DM_MemRead, DM_MemWrite;
    logic [31:0] RData0, RData1, DM_Addr, DM_WriteData, DM_ReadData;

    logic        f_req0, f_req1;
    logic        f_ack0, f_ack1, f_busy, f_mrd, f_mwr;
    logic [31:0] f_rdata0, f_rdata1, f_addr, f_wdata;
    logic [31:0] f_rd_mem;

    logic [31:0] mem [0:63];
    logic        pre_vld;
    logic [5:0]  pre_addr;
    logic [31:0] pre_dat;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int ack0_cnt = 0;
    int both_cnt = 0;
    int wr_base, ack_base, g;

    dm_arbiter #(.RR_EN(1'b1), .DATA_W(32)) dut (
        .Clk(Clk), .Rst(Rst),
        .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
        .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
        .BE0(BE0), .BE1(BE1),
        .Ack0(Ack0), .Ack1(Ack1), .RData0(RData0), .RData1(RData1), .Busy(Busy),
        .DM_Addr(DM_Addr), .DM_WriteData(DM_WriteData),
        .DM_MemRead(DM_MemRead), .DM_MemWrite(DM_MemWrite), .DM_ReadData(DM_ReadData)
    );

    dm_arbiter #(.RR_EN(1'b0), .DATA_W(32)) dut_fp (
        .Clk(Clk), .Rst(Rst),
        .Req0(f_req0), .Req1(f_req1), .We0(1'b0), .We1(1'b0),
        .Addr0(32'h0), .Addr1(32'h4), .WData0(32'h0), .WData1(32'h0),
        .BE0(4'h0), .BE1(4'h0),
        .Ack0(f_ack0), .Ack1(f_ack1), .RData0(f_rdata0), .RData1(f_rdata1), .Busy(f_busy),
        .DM_Addr(f_addr), .DM_WriteData(f_wdata),
        .DM_MemRead(f_mrd), .DM_MemWrite(f_mwr), .DM_ReadData(f_rd_mem)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Single-ported memory: combinational read, write committed at the rising edge.
    assign DM_ReadData = mem[DM_Addr[7:2]];
    assign f_rd_mem    = 32'h0;

    always @(posedge Clk) begin
        if (pre_vld)          mem[pre_addr] <= pre_dat;
        else if (DM_MemWrite) mem[DM_Addr[7:2]] <= DM_WriteData;
    end

    // Event counters for properties that span several cycles.
    always @(posedge Clk) begin
        if (DM_MemWrite)               wr_cnt   <= wr_cnt + 1;
        if (Ack0)                      ack0_cnt <= ack0_cnt + 1;
        if ((Ack0 && Ack1) || (f_ack0 && f_ack1)) both_cnt <= both_cnt + 1;
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        Rst = 1'b0;
        Req0 = 0; Req1 = 0; We0 = 0; We1 = 0;
        Addr0 = 0; Addr1 = 0; WData0 = 0; WData1 = 0; BE0 = 0; BE1 = 0;
        f_req0 = 0; f_req1 = 0;
        pre_vld = 1; pre_addr = 6'd4; pre_dat = 32'hDEADBEEF;
        tick;
        pre_addr = 6'd12; pre_dat = 32'hAABBCCDD;
        tick;
        pre_vld = 0;

        // Reset state
        chk("rst_busy", {31'b0, Busy}, 32'h0);
        chk("rst_ack0", {31'b0, Ack0}, 32'h0);
        chk("rst_ack1", {31'b0, Ack1}, 32'h0);
        chk("rst_mrd", {31'b0, DM_MemRead}, 32'h0);
        chk("rst_mwr", {31'b0, DM_MemWrite}, 32'h0);
        chk("rst_addr", DM_Addr, 32'h0);
        chk("rst_rdata0", RData0, 32'h0);
        Rst = 1'b1;
        tick;

        // Port 0 read of 0x10
        wr_base = wr_cnt;
        Req0 = 1; We0 = 0; Addr0 = 32'h10;
        tick;
        chk("t1_access_mrd", {31'b0, DM_MemRead}, 32'h1);
        chk("t1_access_addr", DM_Addr, 32'h10);
        chk("t1_access_ack0", {31'b0, Ack0}, 32'h0);
        tick;
        chk("t1_ack0", {31'b0, Ack0}, 32'h1);
        chk("t1_rdata0", RData0, 32'hDEADBEEF);
        chk("t1_no_write", wr_cnt, wr_base);
        Req0 = 0;

        // Port 1 full-word write to 0x20
        wr_base = wr_cnt;
        Req1 = 1; We1 = 1; Addr1 = 32'h20; WData1 = 32'h12345678; BE1 = 4'hF;
        tick;
        tick;
        chk("t2_mwr", {31'b0, DM_MemWrite}, 32'h1);
        chk("t2_wdata", DM_WriteData, 32'h12345678);
        chk("t2_addr", DM_Addr, 32'h20);
        tick;
        chk("t2_ack1", {31'b0, Ack1}, 32'h1);
        chk("t2_ack0", {31'b0, Ack0}, 32'h0);
        chk("t2_mem", mem[8], 32'h12345678);
        chk("t2_one_write", wr_cnt, wr_base + 1);
        Req1 = 0;

        // Port 0 partial write, read-modify-write
        Req0 = 1; We0 = 1; Addr0 = 32'h30; WData0 = 32'h11223344; BE0 = 4'b0101;
        tick;
        tick;
        chk("t3_access_mrd", {31'b0, DM_MemRead}, 32'h1);
        chk("t3_access_mwr", {31'b0, DM_MemWrite}, 32'h0);
        tick;
        chk("t3_merge_mwr", {31'b0, DM_MemWrite}, 32'h1);
        chk("t3_merge_wdata", DM_WriteData, 32'hAA22CC44);
        chk("t3_merge_ack0", {31'b0, Ack0}, 32'h0);
        tick;
        chk("t3_ack0", {31'b0, Ack0}, 32'h1);
        chk("t3_mem", mem[12], 32'hAA22CC44);
        Req0 = 0;

        // Unaligned read address
        Req0 = 1; We0 = 0; Addr0 = 32'h13;
        tick;
        tick;
        chk("t6_aligned_addr", DM_Addr, 32'h10);
        tick;
        chk("t6_ack0", {31'b0, Ack0}, 32'h1);
        chk("t6_rdata0", RData0, 32'hDEADBEEF);
        Req0 = 0;

        // BE=0 write leaves memory untouched
        wr_base = wr_cnt;
        Req1 = 1; We1 = 1; Addr1 = 32'h20; WData1 = 32'hFFFFFFFF; BE1 = 4'h0;
        tick;
        tick;
        chk("t6_be0_mwr", {31'b0, DM_MemWrite}, 32'h0);
        tick;
        chk("t6_be0_ack1", {31'b0, Ack1}, 32'h1);
        chk("t6_be0_mem", mem[8], 32'h12345678);
        chk("t6_be0_nowr", wr_cnt, wr_base);

        // Round-robin with both requests held: grants 0,1,0,1
        Req0 = 1; We0 = 0; Addr0 = 32'h10;
        Req1 = 1; We1 = 0; Addr1 = 32'h20;
        for (int i = 0; i < 4; i++) begin
            g = i % 2;
            tick;
            tick;
            tick;
            chk($sformatf("t4_rr%0d_ack0", i), {31'b0, Ack0}, (g == 0) ? 32'h1 : 32'h0);
            chk($sformatf("t4_rr%0d_ack1", i), {31'b0, Ack1}, (g == 1) ? 32'h1 : 32'h0);
            if (g == 0) chk($sformatf("t4_rr%0d_rdata0", i), RData0, 32'hDEADBEEF);
            else        chk($sformatf("t4_rr%0d_rdata1", i), RData1, 32'h12345678);
        end
        Req0 = 0; Req1 = 0;
        tick;

        // Fixed priority: port 0 wins every tie, port 1 only after Req0 drops
        f_req0 = 1; f_req1 = 1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick;
            tick;
            tick;
            chk($sformatf("t4_fp%0d_ack0", i), {31'b0, f_ack0}, 32'h1);
            chk($sformatf("t4_fp%0d_ack1", i), {31'b0, f_ack1}, 32'h0);
        end
        f_req0 = 0;
        tick;
        tick;
        tick;
        chk("t4_fp_port1_ack1", {31'b0, f_ack1}, 32'h1);
        chk("t4_fp_port1_ack0", {31'b0, f_ack0}, 32'h0);
        f_req1 = 0;
        tick;

        // Reset asserted during MERGE
        ack_base = ack0_cnt;
        Req0 = 1; We0 = 1; Addr0 = 32'h30; WData0 = 32'h55667788; BE0 = 4'b0011;
        tick;
        tick;
        chk("t5_in_merge", {31'b0, DM_MemWrite}, 32'h1);
        #2;
        Rst = 1'b0;
        #1;
        chk("t5_rst_busy", {31'b0, Busy}, 32'h0);
        chk("t5_rst_mwr", {31'b0, DM_MemWrite}, 32'h0);
        chk("t5_rst_wdata", DM_WriteData, 32'h0);
        chk("t5_rst_addr", DM_Addr, 32'h0);
        tick;
        tick;
        chk("t5_mem_unchanged", mem[12], 32'hAA22CC44);
        chk("t5_no_ack", ack0_cnt, ack_base);
        Rst = 1'b1;
        tick;
        chk("t5_regrant_busy", {31'b0, Busy}, 32'h1);
        chk("t5_regrant_addr", DM_Addr, 32'h30);
        tick;
        tick;
        chk("t5_ack0", {31'b0, Ack0}, 32'h1);
        chk("t5_mem", mem[12], 32'hAA227788);
        Req0 = 0;
        tick;

        chk("never_both_acks", both_cnt, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
